// File: rtl/lzrw1_stream_parser.sv
// lzrw1_stream_parser
//   Front end of the LZRW1 decompressor. Accepts the compressed byte stream,
//   splits it into groups of a 16-bit control word followed by up to 16 items,
//   and hands one item per transfer downstream as a 16-bit word plus its
//   control bit (1 = copy, 0 = literal).
// Ports
//   i_clock, i_reset            clock, synchronous active-high reset
//   i_byte_in[7:0]              compressed stream byte
//   i_byte_in_valid/_last       byte valid / byte is the final stream byte
//   o_byte_in_ready             byte accepted when valid && ready at clock edge
//   o_data_out[15:0]            literal {8'h00,lit}; copy {first,second}
//   o_control_word_out          control bit of the presented item
//   o_data_out_valid            item presented; taken when !i_decompressor_busy
//   i_decompressor_busy         downstream stall
//   o_parse_done/o_parse_error  sticky completion / truncated-stream flags
//   o_items_emitted             count of items handed off (wraps)
module lzrw1_stream_parser #(
  parameter int unsigned HEADER_BYTES     = 0,
  parameter int unsigned ITEM_COUNT_WIDTH = 16
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic [7:0]                  i_byte_in,
  input  logic                        i_byte_in_valid,
  input  logic                        i_byte_in_last,
  output logic                        o_byte_in_ready,
  output logic [15:0]                 o_data_out,
  output logic                        o_control_word_out,
  output logic                        o_data_out_valid,
  input  logic                        i_decompressor_busy,
  output logic                        o_parse_done,
  output logic                        o_parse_error,
  output logic [ITEM_COUNT_WIDTH-1:0] o_items_emitted
);

  localparam int unsigned HDR_W    = (HEADER_BYTES > 1) ? $clog2(HEADER_BYTES) : 1;
  localparam int unsigned HDR_LAST = (HEADER_BYTES > 0) ? HEADER_BYTES - 1 : 0;

  typedef enum logic [2:0] {
    S_HDR, S_CW_LO, S_CW_HI, S_ITEM_B0, S_ITEM_B1, S_EMIT, S_DONE, S_ERROR
  } state_t;

  localparam state_t RESET_STATE = (HEADER_BYTES > 0) ? S_HDR : S_CW_LO;

  state_t                      r_state;
  logic [HDR_W-1:0]            r_hdr_cnt;
  logic [15:0]                 r_cw;
  logic [3:0]                  r_idx;
  logic                        r_last_seen;
  logic [15:0]                 r_data;
  logic                        r_ctrl;
  logic                        r_valid;
  logic                        r_ready;
  logic                        r_done;
  logic                        r_error;
  logic [ITEM_COUNT_WIDTH-1:0] r_items;

  state_t w_next_state;
  logic   w_accept;
  logic   w_handoff;
  logic   w_cw_bit;
  logic   w_next_ready;

  // Handshakes use the registered ready/valid so they match what the ports show.
  assign w_accept  = i_byte_in_valid && r_ready;
  assign w_handoff = r_valid && !i_decompressor_busy;
  assign w_cw_bit  = r_cw[r_idx];

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_HDR: begin
        if (w_accept) begin
          if (i_byte_in_last)                     w_next_state = S_ERROR;
          else if (r_hdr_cnt == HDR_W'(HDR_LAST)) w_next_state = S_CW_LO;
        end
      end
      S_CW_LO: begin
        if (w_accept) w_next_state = i_byte_in_last ? S_ERROR : S_CW_HI;
      end
      S_CW_HI: begin
        // A stream may legally end right after a control word (empty group).
        if (w_accept) w_next_state = i_byte_in_last ? S_DONE : S_ITEM_B0;
      end
      S_ITEM_B0: begin
        if (w_accept) begin
          if (!w_cw_bit)           w_next_state = S_EMIT;
          else if (i_byte_in_last) w_next_state = S_ERROR;
          else                     w_next_state = S_ITEM_B1;
        end
      end
      S_ITEM_B1: begin
        if (w_accept) w_next_state = S_EMIT;
      end
      S_EMIT: begin
        if (w_handoff) begin
          if (r_last_seen)         w_next_state = S_DONE;
          else if (r_idx == 4'd15) w_next_state = S_CW_LO;
          else                     w_next_state = S_ITEM_B0;
        end
      end
      S_DONE:  w_next_state = S_DONE;
      S_ERROR: w_next_state = S_ERROR;
      default: w_next_state = RESET_STATE;
    endcase
  end

  // Ready is high in every byte-consuming state.
  always_comb begin
    w_next_ready = 1'b0;
    case (w_next_state)
      S_HDR, S_CW_LO, S_CW_HI, S_ITEM_B0, S_ITEM_B1: w_next_ready = 1'b1;
      default:                                       w_next_ready = 1'b0;
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= RESET_STATE;
      r_hdr_cnt   <= '0;
      r_cw        <= '0;
      r_idx       <= '0;
      r_last_seen <= 1'b0;
      r_data      <= '0;
      r_ctrl      <= 1'b0;
      r_valid     <= 1'b0;
      r_ready     <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_items     <= '0;
    end else begin
      r_state <= w_next_state;
      r_ready <= w_next_ready;
      r_valid <= (w_next_state == S_EMIT);
      r_done  <= r_done  | (w_next_state == S_DONE);
      r_error <= r_error | (w_next_state == S_ERROR);

      if (w_accept) begin
        r_last_seen <= r_last_seen | i_byte_in_last;
        case (r_state)
          S_HDR:   r_hdr_cnt <= HDR_W'(r_hdr_cnt + HDR_W'(1));
          S_CW_LO: r_cw[7:0] <= i_byte_in;
          S_CW_HI: begin
            r_cw[15:8] <= i_byte_in;
            r_idx      <= '0;
          end
          S_ITEM_B0: begin
            r_ctrl <= w_cw_bit;
            if (!w_cw_bit) r_data       <= {8'h00, i_byte_in};
            else           r_data[15:8] <= i_byte_in;
          end
          S_ITEM_B1: r_data[7:0] <= i_byte_in;
          default: ;
        endcase
      end

      // idx wraps 15 -> 0 naturally; CW_HI also clears it for the next group.
      if (w_handoff) begin
        r_items <= ITEM_COUNT_WIDTH'(r_items + ITEM_COUNT_WIDTH'(1));
        r_idx   <= 4'(r_idx + 4'd1);
      end
    end
  end

  assign o_byte_in_ready    = r_ready;
  assign o_data_out         = r_data;
  assign o_control_word_out = r_ctrl;
  assign o_data_out_valid   = r_valid;
  assign o_parse_done       = r_done;
  assign o_parse_error      = r_error;
  assign o_items_emitted    = r_items;

endmodule

// File: tb/tb_lzrw1_stream_parser.sv
// Testbench for lzrw1_stream_parser: directed streams plus random streams with
// random valid gaps and downstream stalls, checked against a byte-level parser model.
module tb_lzrw1_stream_parser;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [7:0]  i_byte = 8'h00;
  logic        i_valid = 1'b0;
  logic        i_last = 1'b0;
  logic        i_busy = 1'b0;
  logic        o_ready;
  logic [15:0] o_data;
  logic        o_ctrl;
  logic        o_valid;
  logic        o_done;
  logic        o_error;
  logic [15:0] o_items;

  always #5 clk = ~clk;

  lzrw1_stream_parser dut (
    .i_clock             (clk),
    .i_reset             (i_reset),
    .i_byte_in           (i_byte),
    .i_byte_in_valid     (i_valid),
    .i_byte_in_last      (i_last),
    .o_byte_in_ready     (o_ready),
    .o_data_out          (o_data),
    .o_control_word_out  (o_ctrl),
    .o_data_out_valid    (o_valid),
    .i_decompressor_busy (i_busy),
    .o_parse_done        (o_done),
    .o_parse_error       (o_error),
    .o_items_emitted     (o_items)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  stim_q[$];
  logic [16:0] exp_q[$];
  logic [16:0] got_q[$];
  bit          exp_done;
  bit          exp_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference parser: walks the byte list once, group by group.
  function automatic void model();
    int n;
    int p;
    logic [15:0] cw;
    n = stim_q.size();
    p = 0;
    exp_q.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    while (1) begin
      if (p == n - 1) begin exp_err = 1'b1; return; end
      cw = {stim_q[p+1], stim_q[p]};
      if (p + 1 == n - 1) begin exp_done = 1'b1; return; end
      p += 2;
      for (int i = 0; i < 16; i++) begin
        if (!cw[i]) begin
          exp_q.push_back({1'b0, 8'h00, stim_q[p]});
          if (p == n - 1) begin exp_done = 1'b1; return; end
          p += 1;
        end else begin
          if (p == n - 1) begin exp_err = 1'b1; return; end
          exp_q.push_back({1'b1, stim_q[p], stim_q[p+1]});
          if (p + 1 == n - 1) begin exp_done = 1'b1; return; end
          p += 2;
        end
      end
    end
  endfunction

  function automatic logic [63:0] got_at(input int i);
    if (i < got_q.size()) return 64'(got_q[i]);
    return 64'hFFFF_FFFF;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    i_reset = 1'b1;
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_busy  = 1'b0;
    @(negedge clk);
    check("reset_outputs",
          64'({o_ready, o_valid, o_done, o_error, o_ctrl, o_data, o_items}), 64'(0));
    i_reset = 1'b0;
  endtask

  // Feed stim_q with valid_pct/busy_pct gaps; force_item >= 0 stalls that item 5 cycles.
  task automatic run_stream(input int vpct, input int bpct, input int force_item);
    int ptr;
    int cyc;
    int fcnt;
    int n;
    logic busy;
    bit held_v;
    logic [16:0] held;
    ptr = 0; cyc = 0; fcnt = 0; held_v = 1'b0; held = '0;
    n = stim_q.size();
    got_q.delete();
    model();
    do_reset();
    while (1) begin
      @(negedge clk);
      if (o_done || o_error) break;
      cyc++;
      if (cyc > 4000) begin
        check("timeout", 64'(cyc), 64'(0));
        break;
      end
      busy = (int'($urandom_range(99)) < bpct);
      if (force_item >= 0 && o_valid && got_q.size() == force_item && fcnt < 5) begin
        busy = 1'b1;
        fcnt++;
        check("busy_ready", 64'(o_ready), 64'(0));
      end
      i_busy = busy;
      if (held_v && o_valid) check("hold_stable", 64'({o_ctrl, o_data}), 64'(held));
      held_v = o_valid && busy;
      held   = {o_ctrl, o_data};
      if (o_valid && !busy) got_q.push_back({o_ctrl, o_data});
      if (ptr < n && int'($urandom_range(99)) < vpct) begin
        i_valid = 1'b1;
        i_byte  = stim_q[ptr];
        i_last  = (ptr == n - 1);
        if (o_ready) ptr++;
      end else begin
        i_valid = 1'b0;
        i_byte  = 8'($urandom);
        i_last  = 1'($urandom);
      end
    end
    i_valid = 1'b0;
    i_busy  = 1'b0;
    i_last  = 1'b0;
    check("parse_done",  64'(o_done),  64'(exp_done));
    check("parse_error", 64'(o_error), 64'(exp_err));
    check("items_emitted", 64'(o_items), 64'(exp_q.size()));
    check("item_count", 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) check("item", got_at(i), 64'(exp_q[i]));
    // Terminal states ignore further input.
    repeat (2) begin
      @(negedge clk);
      i_valid = 1'b1;
      i_byte  = 8'($urandom);
      i_last  = 1'($urandom);
      @(negedge clk);
      check("terminal_idle", 64'({o_ready, o_valid, o_items}), 64'({2'b00, 16'(exp_q.size())}));
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  initial begin
    int cyc;
    int ptr;
    int len;

    // 1: three literals
    stim_q = '{8'h00, 8'h00, 8'h41, 8'h42, 8'h43};
    run_stream(100, 0, -1);
    check("t1_item0", got_at(0), 64'({1'b0, 16'h0041}));
    check("t1_item2", got_at(2), 64'({1'b0, 16'h0043}));
    check("t1_count", 64'(o_items), 64'(3));

    // 2: literal, copy, literal
    stim_q = '{8'h02, 8'h00, 8'h41, 8'h12, 8'h34, 8'h42};
    run_stream(100, 0, -1);
    check("t2_copy", got_at(1), 64'({1'b1, 16'h1234}));
    check("t2_done", 64'(o_done), 64'(1));

    // 3: a full literal group, then a new group holding one copy
    stim_q = '{8'h00, 8'h00};
    for (int i = 0; i < 16; i++) stim_q.push_back(8'($urandom));
    stim_q.push_back(8'hFF); stim_q.push_back(8'hFF);
    stim_q.push_back(8'hAB); stim_q.push_back(8'hCD);
    run_stream(70, 30, -1);
    check("t3_item16", got_at(16), 64'({1'b1, 16'hABCD}));
    check("t3_count", 64'(o_items), 64'(17));

    // 4: stall item 2 of stream 1 for 5 cycles
    stim_q = '{8'h00, 8'h00, 8'h41, 8'h42, 8'h43};
    run_stream(100, 0, 1);
    check("t4_item1", got_at(1), 64'({1'b0, 16'h0042}));
    check("t4_count", 64'(o_items), 64'(3));

    // 5: stream ends on the first byte of a copy
    stim_q = '{8'h01, 8'h00, 8'h12};
    run_stream(100, 0, -1);
    check("t5_error", 64'(o_error), 64'(1));
    check("t5_count", 64'(o_items), 64'(0));

    // 6: reset while an item is pending, then restart with stream 1
    stim_q = '{8'h02, 8'h00, 8'h41, 8'h12, 8'h34, 8'h42};
    do_reset();
    i_busy = 1'b1;
    ptr = 0;
    cyc = 0;
    while (1) begin
      @(negedge clk);
      if (o_valid || cyc > 50) break;
      cyc++;
      i_valid = 1'b1;
      i_byte  = stim_q[ptr];
      i_last  = (ptr == stim_q.size() - 1);
      if (o_ready) ptr++;
    end
    check("t6_pending", 64'(o_valid), 64'(1));
    i_valid = 1'b0;
    i_reset = 1'b1;
    @(posedge clk);
    #1;
    check("t6_reset_drops_valid", 64'(o_valid), 64'(0));
    i_reset = 1'b0;
    i_busy  = 1'b0;
    stim_q = '{8'h00, 8'h00, 8'h41, 8'h42, 8'h43};
    run_stream(100, 0, -1);
    check("t6_count", 64'(o_items), 64'(3));
    check("t6_item0", got_at(0), 64'({1'b0, 16'h0041}));

    // Random streams truncated at random points: exercises every end condition.
    repeat (40) begin
      len = int'($urandom_range(80, 1));
      stim_q.delete();
      for (int i = 0; i < len; i++) stim_q.push_back(8'($urandom));
      run_stream(int'($urandom_range(100, 30)), int'($urandom_range(60, 0)), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
